// File: rtl/lu_arbiter.sv
// Arbiter sharing one registered AND-OR logic unit among N_REQ requesters.
// Define LU_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module lu_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic             tukli,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op_a,
  input  logic [N_REQ-1:0] op_b,
  input  logic [N_REQ-1:0] op_c,
  output logic [N_REQ-1:0] gnt,
  output logic             lu_a,
  output logic             lu_b,
  output logic             lu_c,
  input  logic             lu_y,
  input  logic             lu_z,
  output logic             resp_valid,
  output logic [ID_W-1:0]  resp_id,
  output logic             resp_y,
  output logic             resp_z,
  output logic             busy,
  output logic [CNT_W-1:0] issue_cnt
);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } stage_t;

  stage_t           s1;
  stage_t           s2;
  logic             win_vld;
  logic [ID_W-1:0]  win_id;
  logic [N_REQ-1:0] win_oh;

`ifdef LU_ARB_RR_EN
  logic [ID_W-1:0]  ptr;

  // Search starts just after the last winner and wraps modulo N_REQ.
  always_comb begin
    int cand;
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    win_vld = 1'b0;
    win_id  = '0;
    cand    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_vld && ((req >> cand) & N_REQ'(1)) != '0) begin
        win_vld = 1'b1;
        win_id  = ID_W'(cand);
      end
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && ((req >> i) & N_REQ'(1)) != '0) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end
`endif

  assign win_oh = win_vld ? (N_REQ'(1) << win_id) : '0;
  assign busy   = s1.vld | s2.vld;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tukli) begin
    if (rst) begin
      gnt        <= '0;
      lu_a       <= 1'b0;
      lu_b       <= 1'b0;
      lu_c       <= 1'b0;
      s1         <= '0;
      s2         <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_y     <= 1'b0;
      resp_z     <= 1'b0;
      issue_cnt  <= '0;
`ifdef LU_ARB_RR_EN
      ptr        <= ID_W'(N_REQ - 1);
`endif
    end else begin
      gnt    <= win_oh;
      s1.vld <= win_vld;
      s1.id  <= win_id;
      s2     <= s1;
      if (win_vld) begin
        lu_a      <= |(op_a & win_oh);
        lu_b      <= |(op_b & win_oh);
        lu_c      <= |(op_c & win_oh);
        issue_cnt <= issue_cnt + CNT_W'(1);
`ifdef LU_ARB_RR_EN
        ptr       <= win_id;
`endif
      end
      // The unit is unreset; only sample it when a tracked operation is due.
      resp_valid <= s2.vld;
      if (s2.vld) begin
        resp_id <= s2.id;
        resp_y  <= lu_y;
        resp_z  <= lu_z;
      end
    end
  end

  a_gnt_onehot : assert property (@(posedge tukli) disable iff (rst) $onehot0(gnt));
  a_busy_resp  : assert property (@(posedge tukli) disable iff (rst) gnt != '0 |-> busy);

endmodule

// File: tb/tb_lu_arbiter.sv
// Self-checking bench for lu_arbiter: cycle model plus a response scoreboard queue.
// Follows LU_ARB_RR_EN to pick round-robin or fixed-priority expectations.
module tb_lu_arbiter;

  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 3;

  logic             tukli;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic [N-1:0]     op_c;
  logic [N-1:0]     gnt;
  logic             lu_a;
  logic             lu_b;
  logic             lu_c;
  logic             lu_y;
  logic             lu_z;
  logic             resp_valid;
  logic [ID_W-1:0]  resp_id;
  logic             resp_y;
  logic             resp_z;
  logic             busy;
  logic [CNT_W-1:0] issue_cnt;

  lu_arbiter #(.N_REQ(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .tukli(tukli), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .gnt(gnt), .lu_a(lu_a), .lu_b(lu_b), .lu_c(lu_c), .lu_y(lu_y), .lu_z(lu_z),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_y(resp_y), .resp_z(resp_z),
    .busy(busy), .issue_cnt(issue_cnt)
  );

  // Shared logic unit: registered, never reset.
  always_ff @(posedge tukli) begin
    lu_y <= (lu_a & lu_b) | lu_c;
    lu_z <= ~((lu_a & lu_b) | lu_c);
  end

  initial tukli = 1'b0;
  always #5 tukli = ~tukli;

  typedef struct {
    int   due;
    int   id;
    logic y;
    logic z;
  } exp_t;

  exp_t             q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  int               ptr_m    = N - 1;
  logic [CNT_W-1:0] cnt_m    = '0;
  logic [N-1:0]     exp_gnt  = '0;
  logic             la_m = 1'b0, lb_m = 1'b0, lc_m = 1'b0;
  logic             s1_m = 1'b0, s2_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance the model on the inputs present at the coming edge, then compare after it.
  task automatic tick();
    int         w;
    logic [N-1:0] t;
    logic       y;
    w = -1;
    if (rst) begin
      q.delete();
      ptr_m = N - 1;
      cnt_m = '0;
      s1_m = 1'b0; s2_m = 1'b0;
      la_m = 1'b0; lb_m = 1'b0; lc_m = 1'b0;
      exp_gnt = '0;
    end else begin
`ifdef LU_ARB_RR_EN
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (ptr_m + k) % N;
        t = req >> c;
        if (w < 0 && t[0]) w = c;
      end
`else
      for (int k = 0; k < N; k++) begin
        t = req >> k;
        if (w < 0 && t[0]) w = k;
      end
`endif
      s2_m = s1_m;
      s1_m = (w >= 0);
      exp_gnt = (w >= 0) ? (N'(1) << w) : '0;
      if (w >= 0) begin
        ptr_m = w;
        cnt_m = cnt_m + 1'b1;
        t = op_a >> w; la_m = t[0];
        t = op_b >> w; lb_m = t[0];
        t = op_c >> w; lc_m = t[0];
        y = (la_m & lb_m) | lc_m;
        q.push_back('{due: cyc + 3, id: w, y: y, z: ~y});
      end
    end
    @(posedge tukli);
    #1;
    cyc++;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("busy", 32'(busy), 32'(s1_m | s2_m));
    check("issue_cnt", 32'(issue_cnt), 32'(cnt_m));
    check("lu_a", 32'(lu_a), 32'(la_m));
    check("lu_b", 32'(lu_b), 32'(lb_m));
    check("lu_c", 32'(lu_c), 32'(lc_m));
    if (q.size() > 0 && q[0].due == cyc) begin
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_id", 32'(resp_id), 32'(q[0].id));
      check("resp_y", 32'(resp_y), 32'(q[0].y));
      check("resp_z", 32'(resp_z), 32'(q[0].z));
      void'(q.pop_front());
    end else begin
      check("resp_valid_idle", 32'(resp_valid), 32'd0);
    end
  endtask

  task automatic set_ops(input int r, input logic a, input logic b, input logic c);
    op_a = N'(a) << r;
    op_b = N'(b) << r;
    op_c = N'(c) << r;
  endtask

  initial begin
    int exp_id;
    rst = 1'b1; req = '0; op_a = '0; op_b = '0; op_c = '0;

    // Reset, and a request during reset is ignored.
    tick();
    req = 4'b0101;
    tick();
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_y", 32'(resp_y), 32'd0);
    check("rst_resp_z", 32'(resp_z), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    req = '0; rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // Single operation on requester 2.
    req = 4'b0100; set_ops(2, 1'b1, 1'b1, 1'b0);
    tick();
    check("single_gnt", 32'(gnt), 32'b0100);
    req = '0;
    tick();
    tick();
    check("single_valid", 32'(resp_valid), 32'd1);
    check("single_id", 32'(resp_id), 32'd2);
    check("single_y", 32'(resp_y), 32'd1);
    check("single_z", 32'(resp_z), 32'd0);
    check("single_cnt", 32'(issue_cnt), 32'd1);
    for (int i = 0; i < 2; i++) tick();

    // All requesters held high from a fresh reset.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      op_a = N'($urandom); op_b = N'($urandom); op_c = N'($urandom);
      tick();
`ifdef LU_ARB_RR_EN
      exp_id = k % N;
`else
      exp_id = 0;
`endif
      check("all_req_seq", 32'(gnt), 32'(N'(1) << exp_id));
    end
    req = '0;
    for (int i = 0; i < 3; i++) tick();

    // Operand sweep on requester 1, back to back.
    req = 4'b0010;
    for (int v = 0; v < 8; v++) begin
      set_ops(1, v[2], v[1], v[0]);
      tick();
    end
    req = '0;
    for (int i = 0; i < 3; i++) tick();

    // Reset while an operation is in flight.
    req = 4'b1000; set_ops(3, 1'b0, 1'b0, 1'b1);
    tick();
    req = '0; rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    req = 4'b1111;
    tick();
    check("midrst_first", 32'(gnt), 32'b0001);
    req = '0;
    for (int i = 0; i < 3; i++) tick();

    // Counter wrap: 9 grants on a 3-bit counter.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0001; set_ops(0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    req = '0;
    tick();
    check("cnt_wrap", 32'(issue_cnt), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
